// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and data-memory wait.
// Optional hazard performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      id_inst,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] dmem_wait_cycles
);

  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_OP    = 7'b0110011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [16:0] TO_LIM   = 17'(TIMEOUT);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic [16:0] wait_inc;
  logic [6:0]  opcode;
  logic        uses_rs1, uses_rs2, lu, frz;
  logic        unused_inst_bits;

  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  assign opcode   = id_inst[6:0];
  assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign uses_rs2 = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BR);
  assign lu       = ex_memread && (ex_rd != 5'd0) &&
                    ((uses_rs1 && ex_rd == id_inst[19:15]) ||
                     (uses_rs2 && ex_rd == id_inst[24:20]));
  assign frz      = mem_access && !dmem_ack;
  assign wait_inc = {1'b0, wait_cnt} + 17'd1;

  // Zero-latency enable/flush decode; freeze outranks branch, branch outranks load-use
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_flush = 1'b0;
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (frz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (frz) state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_ack || !mem_access) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Wait counter runs over every frozen cycle and clears whenever the freeze lifts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!frz)
        wait_cnt <= 16'd0;
      else if (!(&wait_cnt))
        wait_cnt <= wait_inc[15:0];
      if (frz && wait_inc >= TO_LIM)
        mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles     <= '0;
      flush_count      <= '0;
      dmem_wait_cycles <= '0;
    end else begin
      if (frz || (!ex_branch_taken && lu))
        stall_cycles <= sat_inc(stall_cycles);
      if (!frz && ex_branch_taken)
        flush_count <= sat_inc(flush_count);
      if (frz)
        dmem_wait_cycles <= sat_inc(dmem_wait_cycles);
    end
  end
`else
  assign stall_cycles     = '0;
  assign flush_count      = '0;
  assign dmem_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: decode table plus wait, timeout and reset sequences.
module tb_pipeline_hazard_controller;

  localparam logic [6:0]  NORM = 7'b1101010;
  localparam logic [6:0]  LU   = 7'b0001110;
  localparam logic [6:0]  BR   = 7'b1111110;
  localparam logic [6:0]  FRZ  = 7'b0000001;
  localparam logic [6:0]  RST  = 7'b0010101;
  localparam logic [31:0] NOP  = 32'h00000013;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] id_inst;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken, mem_access, dmem_ack;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_write, memwb_flush, mem_timeout;
  logic [31:0] stall_cycles, flush_count, dmem_wait_cycles;
  logic [6:0]  outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_inst(id_inst), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .dmem_ack(dmem_ack), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .memwb_flush(memwb_flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .dmem_wait_cycles(dmem_wait_cycles)
  );

  assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush};

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        mr;
    logic [4:0]  rd;
    logic        br;
    logic        ma;
    logic        ak;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [31:0] inst, input logic mr,
                     input logic [4:0] rd, input logic br, input logic ma,
                     input logic ak, input logic [6:0] exp);
    vec_t v;
    v.name = name; v.inst = inst; v.mr = mr; v.rd = rd;
    v.br = br; v.ma = ma; v.ak = ak; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, leave 2 ns to settle before the caller samples
  task automatic apply(input logic [31:0] inst, input logic mr, input logic [4:0] rd,
                       input logic br, input logic ma, input logic ak);
    @(negedge clk);
    id_inst = inst; ex_memread = mr; ex_rd = rd;
    ex_branch_taken = br; mem_access = ma; dmem_ack = ak;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    apply(NOP, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    id_inst = NOP; ex_memread = 0; ex_rd = 0;
    ex_branch_taken = 0; mem_access = 0; dmem_ack = 0;

    add("lu_add_rs1",     32'h00728333, 1, 5, 0, 0, 0, LU);
    add("lu_rd_zero",     32'h00728333, 1, 0, 0, 0, 0, NORM);
    add("lu_add_rs2",     32'h00728333, 1, 7, 0, 0, 0, LU);
    add("no_memread",     32'h00728333, 0, 5, 0, 0, 0, NORM);
    add("lui_x5",         32'h000052B7, 1, 5, 0, 0, 0, NORM);
    add("lui_rs1field",   32'h000280B7, 1, 5, 0, 0, 0, NORM);
    add("addi_rs1",       32'h00028093, 1, 5, 0, 0, 0, LU);
    add("addi_imm_field", 32'h00500313, 1, 5, 0, 0, 0, NORM);
    add("sw_rs2",         32'h00512023, 1, 5, 0, 0, 0, LU);
    add("beq_rs2",        32'h00508063, 1, 5, 0, 0, 0, LU);
    add("jal_rs1field",   32'h000280EF, 1, 5, 0, 0, 0, NORM);
    add("auipc_rs1field", 32'h00028097, 1, 5, 0, 0, 0, NORM);
    add("br_over_lu",     32'h00728333, 1, 5, 1, 0, 0, BR);
    add("br_alone",       NOP,          0, 0, 1, 0, 0, BR);
    add("frz_over_all",   32'h00728333, 1, 5, 1, 1, 0, FRZ);
    add("ack_same_cycle", NOP,          0, 0, 0, 1, 1, NORM);
    add("ack_with_lu",    32'h00728333, 1, 5, 0, 1, 1, LU);

    // Reset values
    #2;
    check("rst_outs", 32'(outs), 32'(RST));
    check("rst_timeout", 32'(mem_timeout), 0);
    check("rst_stall_cnt", stall_cycles, 0);
    check("rst_flush_cnt", flush_count, 0);
    check("rst_wait_cnt", dmem_wait_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].inst, vecs[i].mr, vecs[i].rd, vecs[i].br, vecs[i].ma, vecs[i].ak);
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
    end
    apply(NOP, 0, 0, 0, 0, 0);
    check("table_no_timeout", 32'(mem_timeout), 0);

    // Three-cycle memory wait with a branch pending, released by ack
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      apply(32'h00728333, 1, 5, 1, 1, 0);
      check($sformatf("wait_frz_%0d", k), 32'(outs), 32'(FRZ));
    end
    apply(32'h00728333, 1, 5, 1, 1, 1);
    check("wait_release_br", 32'(outs), 32'(BR));
    apply(NOP, 0, 0, 0, 0, 0);
    check("wait_idle", 32'(outs), 32'(NORM));
    check("wait_no_timeout", 32'(mem_timeout), 0);
    check("wait_dmem_cnt", dmem_wait_cycles, PERF ? 32'd3 : 32'd0);
    check("wait_stall_cnt", stall_cycles, PERF ? 32'd3 : 32'd0);
    check("wait_flush_cnt", flush_count, PERF ? 32'd1 : 32'd0);

    // Timeout after the 4th wait cycle, sticky through ack, cleared by async reset
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      apply(NOP, 0, 0, 0, 1, 0);
      check($sformatf("to_frz_%0d", k), 32'(outs), 32'(FRZ));
      check($sformatf("to_flag_%0d", k), 32'(mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
    end
    apply(NOP, 0, 0, 0, 1, 1);
    check("to_ack_outs", 32'(outs), 32'(NORM));
    check("to_ack_flag", 32'(mem_timeout), 1);
    apply(NOP, 0, 0, 0, 0, 0);
    check("to_sticky", 32'(mem_timeout), 1);
    #1 reset_n = 1'b0;
    #1;
    check("to_async_clear", 32'(mem_timeout), 0);
    check("to_async_outs", 32'(outs), 32'(RST));
    @(negedge clk);
    reset_n = 1'b1;

    // Reset dropped in the 2nd wait cycle, then a fresh 3-cycle wait stays below TIMEOUT
    do_reset();
    apply(NOP, 0, 0, 0, 1, 0);
    apply(NOP, 0, 0, 0, 1, 0);
    #1 reset_n = 1'b0;
    #1;
    check("midwait_rst_outs", 32'(outs), 32'(RST));
    apply(NOP, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    apply(NOP, 0, 0, 0, 0, 0);
    check("midwait_run_outs", 32'(outs), 32'(NORM));
    check("midwait_timeout", 32'(mem_timeout), 0);
    check("midwait_stall_cnt", stall_cycles, 0);
    check("midwait_flush_cnt", flush_count, 0);
    check("midwait_dmem_cnt", dmem_wait_cycles, 0);
    for (int k = 1; k <= 3; k++) apply(NOP, 0, 0, 0, 1, 0);
    apply(NOP, 0, 0, 0, 1, 1);
    check("midwait_cnt_cleared", 32'(mem_timeout), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Each cycle it combines three conditions into one coherent set of pipeline-register write enables and flushes: load-use hazards between ID and EX, taken branches/jumps resolved in EX, and data-memory wait states signalled by a request/acknowledge handshake. It also runs a bounded wait timer for the data memory and, optionally, hazard performance counters.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum consecutive data-memory wait cycles before `mem_timeout` sets. Legal range 1..65535.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  single pipeline clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_inst`  in  32  instruction in IF/ID.
- `ex_memread`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_branch_taken`  in  1  EX resolved a taken branch, JAL or JALR.
- `mem_access`  in  1  MEM-stage instruction is a load or store.
- `dmem_ack`  in  1  data memory completes the MEM-stage access this cycle.
- `pc_write`  out  1  PC register load enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  IF/ID cleared to NOP.
- `idex_write`  out  1  ID/EX load enable.
- `idex_flush`  out  1  ID/EX cleared to bubble.
- `exmem_write`  out  1  EX/MEM load enable.
- `memwb_flush`  out  1  MEM/WB loaded with bubble.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`, `flush_count`, `dmem_wait_cycles`  out  CNT_W each  performance counters.

## Operation
- Load-use detection: `lu = ex_memread && ex_rd != 0 && ((uses_rs1 && ex_rd == id_inst[19:15]) || (uses_rs2 && ex_rd == id_inst[24:20]))`.
  - `uses_rs1` is false for opcodes 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL).
  - `uses_rs2` is true only for opcodes 0110011, 0100011 and 1100011.
- Freeze: `frz = mem_access && !dmem_ack`.
- Output priority per cycle, highest first:
  - Freeze: `pc_write`, `ifid_write`, `idex_write` and `exmem_write` are 0; `memwb_flush` is 1; all other flushes are 0. Any branch or load-use condition is re-evaluated after release.
  - Taken branch: `ifid_flush` and `idex_flush` are 1; `pc_write` is 1. The branch overrides load-use.
  - Load-use: `pc_write` and `ifid_write` are 0; `idex_flush` is 1.
  - Otherwise: all write enables are 1 and all flushes are 0.
- `idex_write` and `exmem_write` are 1 in every case except freeze. `memwb_flush` is 1 only during freeze.
- FSM states:
  - RUN to WAIT when `frz` is 1.
  - WAIT to RUN when `dmem_ack` is 1. `mem_access` dropping while in WAIT also returns to RUN (protocol violation, tolerated).
- Wait counter (16 bits):
  - Cleared on entry to RUN.
  - Increments each cycle in WAIT, saturating at 65535.
  - When the count reaches `TIMEOUT`, `mem_timeout` sets and stays set until reset.
  - The freeze continues after timeout; software or reset recovers.

## Timing
- All stall/flush outputs are combinational from the current-cycle inputs, with zero latency.
- The FSM, wait counter, `mem_timeout` and performance counters update on the rising edge of `clk`.
- A load-use stall lasts exactly 1 cycle, because the load then advances and a bubble occupies EX.
- A data access acknowledged in the same cycle it is presented causes 0 stall cycles.
- A WAIT of N cycles freezes the pipeline for N cycles. With `TIMEOUT`=T, `mem_timeout` reads 1 at the edge ending the T-th wait cycle.
- While `reset_n` is 0:
  - All write enables are 0.
  - `ifid_flush`, `idex_flush` and `memwb_flush` are 1.
  - State is RUN; wait counter, `mem_timeout` and all counters are 0.
- Reset asserted mid-WAIT aborts the wait immediately and asynchronously.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every load-use or freeze cycle.
  - `flush_count` increments on every taken-branch flush cycle.
  - `dmem_wait_cycles` increments on every freeze cycle.
  - All three saturate at 2^CNT_W−1 and are cleared by reset.
- Not defined: the three counter outputs are constant 0 and no counter flops are built.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=5, `id_inst`=ADD x6,x5,x7 (0x00728333) → one cycle with `pc_write`=0, `ifid_write`=0, `idex_flush`=1. Same case with `ex_rd`=0 → no stall.
- Opcode qualification: `ex_rd`=5 with `id_inst`=LUI x5 (0x000052B7) → no stall. ADDI x6,x0,5 with `ex_rd` matching the `imm[4:0]` field → no stall.
- Branch overrides load-use: `ex_branch_taken`=1 and `lu` true together → `ifid_flush`=1, `idex_flush`=1, `pc_write`=1; `flush_count` +1.
- Memory wait: `mem_access`=1, `dmem_ack`=0 for 3 cycles then 1 → 3 freeze cycles with `memwb_flush`=1, then RUN; `dmem_wait_cycles`=3; a branch pending during the freeze is applied only after release.
- Timeout: `TIMEOUT`=4, `dmem_ack` held 0 → `mem_timeout`=1 after the 4th wait cycle and still 1 after the ack arrives; cleared only by `reset_n`=0.
- Reset mid-WAIT: drop `reset_n` during the 2nd wait cycle → all outputs take their reset values asynchronously; after release, state is RUN and all counters are 0.
